// File: rtl/operational_unit.sv
// ============================================================================
// Module   : operational_unit
// Purpose  : Four-register datapath with 8-function ALU and carry/zero flags,
//            driven by a 17-bit microinstruction word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module operational_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [16:0]      control_bus,
    input  logic [WIDTH-1:0] data_in,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [2:0] c_OP_PASS = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_AND  = 3'b011;
    localparam logic [2:0] c_OP_OR   = 3'b100;
    localparam logic [2:0] c_OP_XOR  = 3'b101;
    localparam logic [2:0] c_OP_SHL  = 3'b110;
    localparam logic [2:0] c_OP_SHR  = 3'b111;

    logic             w_flag_we;
    logic             w_reg_we;
    logic [2:0]       w_alu_op;
    logic [1:0]       w_dst;
    logic [1:0]       w_src_a;
    logic [1:0]       w_src_b;
    logic             w_imm_sel;
    logic             w_in_sel;
    logic [3:0]       w_imm4;

    logic [WIDTH-1:0] r_regs [4];
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;
    logic [WIDTH:0]   w_wide;

    assign w_flag_we = control_bus[16];
    assign w_reg_we  = control_bus[15];
    assign w_alu_op  = control_bus[14:12];
    assign w_dst     = control_bus[11:10];
    assign w_src_a   = control_bus[9:8];
    assign w_src_b   = control_bus[7:6];
    assign w_imm_sel = control_bus[5];
    assign w_in_sel  = control_bus[4];
    assign w_imm4    = control_bus[3:0];

    // Immediate outranks the external input when both selects are set.
    assign w_a = r_regs[w_src_a];
    assign w_b = w_imm_sel ? WIDTH'(w_imm4) :
                 w_in_sel  ? data_in        : r_regs[w_src_b];

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_wide   = '0;
        case (w_alu_op)
            c_OP_PASS: w_result = w_b;
            c_OP_ADD: begin
                w_wide   = {1'b0, w_a} + {1'b0, w_b};
                w_result = w_wide[WIDTH-1:0];
                w_carry  = w_wide[WIDTH];
            end
            c_OP_SUB: begin
                // Extended subtraction leaves the borrow in the top bit.
                w_wide   = {1'b0, w_a} - {1'b0, w_b};
                w_result = w_wide[WIDTH-1:0];
                w_carry  = w_wide[WIDTH];
            end
            c_OP_AND: w_result = w_a & w_b;
            c_OP_OR:  w_result = w_a | w_b;
            c_OP_XOR: w_result = w_a ^ w_b;
            c_OP_SHL: begin
                w_result = {w_a[WIDTH-2:0], 1'b0};
                w_carry  = w_a[WIDTH-1];
            end
            c_OP_SHR: begin
                w_result = {1'b0, w_a[WIDTH-1:1]};
                w_carry  = w_a[0];
            end
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    assign w_zero = (w_result == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (w_reg_we) begin
                r_regs[w_dst] <= w_result;
            end
            if (w_flag_we) begin
                r_carry <= w_carry;
                r_zero  <= w_zero;
            end
        end
    end

    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign data_out   = r_regs[0];

endmodule

`default_nettype wire

// File: tb/tb_operational_unit.sv
// ============================================================================
// Module   : tb_operational_unit
// Purpose  : Directed self-checking bench for operational_unit (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operational_unit;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic [16:0]      control_bus;
    logic [WIDTH-1:0] data_in;
    logic             carry_flag;
    logic             zero_flag;
    logic [WIDTH-1:0] data_out;

    int n_checks;
    int n_errors;

    operational_unit #(.WIDTH(WIDTH)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .control_bus (control_bus),
        .data_in     (data_in),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .data_out    (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] cw(input logic fwe, input logic rwe, input logic [2:0] op,
                                       input logic [1:0] dst, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic imm,
                                       input logic ins, input logic [3:0] imm4);
        return {fwe, rwe, op, dst, sa, sb, imm, ins, imm4};
    endfunction

    // Apply one control word across one rising edge, return 1 time unit later.
    task automatic exec(input logic [16:0] word, input logic [WIDTH-1:0] din);
        control_bus = word;
        data_in     = din;
        @(posedge clock);
        #1;
    endtask

    task automatic load_in(input logic [1:0] dst, input logic [WIDTH-1:0] val);
        exec(cw(1'b0, 1'b1, 3'b000, dst, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0), val);
    endtask

    // Copy R[n] into R0 without touching flags, then observe it on data_out.
    task automatic read_reg(input string tag, input logic [1:0] n, input logic [WIDTH-1:0] exp);
        exec(cw(1'b0, 1'b1, 3'b000, 2'd0, 2'd0, n, 1'b0, 1'b0, 4'h0), 8'h00);
        check(tag, {24'd0, data_out}, {24'd0, exp});
    endtask

    task automatic check_flags(input string tag, input logic c, input logic z);
        check({tag, "_carry"}, {31'd0, carry_flag}, {31'd0, c});
        check({tag, "_zero"},  {31'd0, zero_flag},  {31'd0, z});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        control_bus = '0;
        data_in     = '0;
        #2;
        check("reset_dout", {24'd0, data_out}, 32'h0);
        check_flags("reset", 1'b0, 1'b0);
        #1 reset = 1'b0;

        // Load immediate 5 into R1 with flag update
        exec(cw(1'b1, 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5), 8'h00);
        check_flags("ldi", 1'b0, 1'b0);
        read_reg("ldi_r1", 2'd1, 8'h05);

        // ADD overflow
        load_in(2'd1, 8'hF0);
        load_in(2'd2, 8'h10);
        exec(cw(1'b1, 1'b1, 3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("add_ovf", 1'b1, 1'b1);
        read_reg("add_ovf_r3", 2'd3, 8'h00);

        // All-zero word is a no-op
        exec(17'd0, 8'hFF);
        check_flags("nop", 1'b1, 1'b1);

        // SUB borrow, then SUB to zero
        exec(cw(1'b0, 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'h3), 8'h00);
        exec(cw(1'b0, 1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5), 8'h00);
        exec(cw(1'b1, 1'b1, 3'b010, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("sub_borrow", 1'b1, 1'b0);
        read_reg("sub_borrow_r3", 2'd3, 8'hFE);
        exec(cw(1'b1, 1'b1, 3'b010, 2'd3, 2'd2, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("sub_zero", 1'b0, 1'b1);
        read_reg("sub_zero_r3", 2'd3, 8'h00);

        // Flag hold with old-value read, then XOR of new R1
        load_in(2'd1, 8'hF0);
        load_in(2'd2, 8'h10);
        exec(cw(1'b1, 1'b0, 3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("set11", 1'b1, 1'b1);
        load_in(2'd1, 8'h81);
        exec(cw(1'b0, 1'b1, 3'b001, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("hold", 1'b1, 1'b1);
        exec(cw(1'b1, 1'b1, 3'b101, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("xor_self", 1'b0, 1'b1);
        read_reg("old_read_r1", 2'd1, 8'h02);

        // Logic ops
        load_in(2'd1, 8'hA5);
        load_in(2'd2, 8'h3C);
        exec(cw(1'b1, 1'b1, 3'b011, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("and", 1'b0, 1'b0);
        read_reg("and_r3", 2'd3, 8'h24);
        exec(cw(1'b0, 1'b1, 3'b100, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        read_reg("or_r3", 2'd3, 8'hBD);
        exec(cw(1'b0, 1'b1, 3'b101, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0), 8'h00);
        read_reg("xor_r3", 2'd3, 8'h99);

        // Shifts ignore operand B (immediate F supplied on purpose)
        load_in(2'd1, 8'h81);
        exec(cw(1'b1, 1'b1, 3'b110, 2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'hF), 8'h00);
        check_flags("shl", 1'b1, 1'b0);
        read_reg("shl_r2", 2'd2, 8'h02);
        exec(cw(1'b1, 1'b1, 3'b111, 2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 4'h0), 8'hFF);
        check_flags("shr", 1'b1, 1'b0);
        read_reg("shr_r2", 2'd2, 8'h40);
        load_in(2'd1, 8'h01);
        exec(cw(1'b1, 1'b1, 3'b111, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 4'h0), 8'h00);
        check_flags("shr_zero", 1'b1, 1'b1);

        // Input path and immediate priority into R0
        exec(cw(1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0), 8'hA5);
        check("in_path", {24'd0, data_out}, 32'hA5);
        exec(cw(1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 4'hC), 8'hA5);
        check("imm_prio", {24'd0, data_out}, 32'h0C);

        // Async reset pulse between edges
        load_in(2'd1, 8'h81);
        load_in(2'd2, 8'h22);
        load_in(2'd3, 8'h33);
        exec(cw(1'b1, 1'b1, 3'b110, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 4'h0), 8'h00);
        check("pre_rst_dout", {24'd0, data_out}, 32'h02);
        check_flags("pre_rst", 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("async_rst_dout", {24'd0, data_out}, 32'h0);
        check_flags("async_rst", 1'b0, 1'b0);
        #1 reset = 1'b0;
        exec(17'd0, 8'h00);
        check("post_rst_dout", {24'd0, data_out}, 32'h0);
        check_flags("post_rst", 1'b0, 1'b0);
        read_reg("post_rst_r1", 2'd1, 8'h00);
        read_reg("post_rst_r3", 2'd3, 8'h00);

        // Write coinciding with an edge while reset is held is discarded
        reset = 1'b1;
        exec(cw(1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'h9), 8'h00);
        check("rst_edge_dout", {24'd0, data_out}, 32'h0);
        reset = 1'b0;
        exec(cw(1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'h9), 8'h00);
        check("first_edge_dout", {24'd0, data_out}, 32'h09);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
